score_argmax: RTL and testbench

Downstream classifier stage for the binarised output layer. It consumes the stream of 9-bit XNOR-popcount class scores produced by the output popcount stage, one score per valid beat, `NUM_CLASSES` beats per frame. Per frame it tracks the best and second-best scores and emits the winning class index, the best score, and the margin and confidence flag as a registered one-cycle result.

---
 rtl/bnn_cls_pkg.sv | 21 ++
 rtl/score_argmax_if.sv | 28 ++
 rtl/score_argmax_top2_update.sv | 38 +++
 rtl/score_argmax.sv | 93 +++++++++
 tb/tb_score_argmax.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/bnn_cls_pkg.sv
// Shared definitions for the binarised-classifier output stages.
// Provides default score width / class count, the class-index width
// derivation, and the argmax frame-collection state encoding.
package bnn_cls_pkg;

  localparam int SCORE_W_DEF     = 9;   // popcount result 0..256
  localparam int NUM_CLASSES_DEF = 10;

  // Smallest index width that can address n classes (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_CLASSES_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/score_argmax_if.sv
// Score stream in / classification result out for score_argmax.
//   score_in, score_in_valid, clear : producer -> argmax
//   class_out, max_score, margin, confident, result_valid, busy : argmax -> consumer
// slave is the argmax side, master the environment side.
interface score_argmax_if #(
  parameter int SCORE_W = 9,
  parameter int IDX_W   = 4
);
  logic [SCORE_W-1:0] score_in;
  logic               score_in_valid;
  logic               clear;
  logic [IDX_W-1:0]   class_out;
  logic [SCORE_W-1:0] max_score;
  logic [SCORE_W-1:0] margin;
  logic               confident;
  logic               result_valid;
  logic               busy;

  modport slave (
    input  score_in, score_in_valid, clear,
    output class_out, max_score, margin, confident, result_valid, busy
  );

  modport master (
    output score_in, score_in_valid, clear,
    input  class_out, max_score, margin, confident, result_valid, busy
  );
endinterface

// File: rtl/score_argmax_top2_update.sv
// top2_update: combinational best/second-best update for one score.
//   best, second, best_idx : current running top-2 state
//   s, idx                 : incoming score and its arrival index
//   first                  : s opens a new frame (previous state ignored)
//   nxt_best, nxt_second, nxt_best_idx : updated state
// Strict compares: a tie keeps the earlier index as best and the equal
// score drops into second, so a tied frame reports margin 0.
module top2_update #(
  parameter int SCORE_W = 9,
  parameter int IDX_W   = 4
) (
  input  logic [SCORE_W-1:0] best,
  input  logic [SCORE_W-1:0] second,
  input  logic [IDX_W-1:0]   best_idx,
  input  logic [SCORE_W-1:0] s,
  input  logic [IDX_W-1:0]   idx,
  input  logic               first,
  output logic [SCORE_W-1:0] nxt_best,
  output logic [SCORE_W-1:0] nxt_second,
  output logic [IDX_W-1:0]   nxt_best_idx
);
  always_comb begin
    nxt_best     = best;
    nxt_second   = second;
    nxt_best_idx = best_idx;
    if (first) begin
      nxt_best     = s;
      nxt_second   = '0;
      nxt_best_idx = '0;
    end else if (s > best) begin
      nxt_second   = best;
      nxt_best     = s;
      nxt_best_idx = idx;
    end else if (s > second) begin
      nxt_second   = s;
    end
  end
endmodule

// File: rtl/score_argmax.sv
// score_argmax: per-frame argmax over NUM_CLASSES streamed class scores.
//   clk, rst : clock, synchronous active-high reset
//   sif      : score_argmax_if.slave
//     in : score_in, score_in_valid (no backpressure), clear (frame abort)
//     out: class_out, max_score, margin, confident, result_valid (1-cycle
//          pulse), busy (frame partially collected)
// The last beat's update bypasses the accumulators and lands directly in
// the result registers, so a new frame may start the very next beat.
module score_argmax
  import bnn_cls_pkg::*;
#(
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int IDX_W       = idx_w(NUM_CLASSES),
  parameter int CONF_MARGIN = 8
) (
  input  logic         clk,
  input  logic         rst,
  score_argmax_if.slave sif
);
  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [SCORE_W-1:0] best, second;
  logic [IDX_W-1:0]   best_idx;

  logic [SCORE_W-1:0] nb, ns, nmargin;
  logic [IDX_W-1:0]   nbi;
  logic               last;

  top2_update #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_upd (
    .best        (best),
    .second      (second),
    .best_idx    (best_idx),
    .s           (sif.score_in),
    .idx         (cnt),
    .first       (state == IDLE),
    .nxt_best    (nb),
    .nxt_second  (ns),
    .nxt_best_idx(nbi)
  );

  // best >= second always holds, so this cannot wrap.
  assign nmargin = nb - ns;
  assign last    = (state == ACCUM) && (cnt == IDX_W'(NUM_CLASSES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      best             <= '0;
      second           <= '0;
      best_idx         <= '0;
      sif.class_out    <= '0;
      sif.max_score    <= '0;
      sif.margin       <= '0;
      sif.confident    <= 1'b0;
      sif.result_valid <= 1'b0;
      sif.busy         <= 1'b0;
    end else begin
      sif.result_valid <= 1'b0;
      if (sif.clear) begin
        // Abort wins over a coincident score; held results stay untouched.
        state    <= IDLE;
        sif.busy <= 1'b0;
        cnt      <= '0;
        best     <= '0;
        second   <= '0;
        best_idx <= '0;
      end else if (sif.score_in_valid) begin
        if (last) begin
          sif.class_out    <= nbi;
          sif.max_score    <= nb;
          sif.margin       <= nmargin;
          sif.confident    <= (nmargin >= SCORE_W'(CONF_MARGIN));
          sif.result_valid <= 1'b1;
          state            <= IDLE;
          sif.busy         <= 1'b0;
          cnt              <= '0;
          best             <= '0;
          second           <= '0;
          best_idx         <= '0;
        end else begin
          state    <= ACCUM;
          sif.busy <= 1'b1;
          cnt      <= cnt + 1'b1;
          best     <= nb;
          second   <= ns;
          best_idx <= nbi;
        end
      end
    end
  end
endmodule

// File: tb/tb_score_argmax.sv
module tb_score_argmax;
  localparam int SW = 9, NC = 10, IW = 4, CM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_argmax_if #(.SCORE_W(SW), .IDX_W(IW)) bus ();

  score_argmax #(.SCORE_W(SW), .NUM_CLASSES(NC), .IDX_W(IW), .CONF_MARGIN(CM)) dut (
    .clk(clk),
    .rst(rst),
    .sif(bus)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int pulses[$];

  // ---------------- behavioural model ----------------
  int  q[$];
  int  e_cls = 0, e_max = 0, e_mar = 0;
  bit  e_conf = 0, e_vld = 0, e_busy = 0;

  // Argmax over a whole frame: first maximum wins; second is the largest
  // of the remaining entries.
  function automatic void eval(input int f[$], output int c, output int mx, output int mg);
    int bi, sec;
    bi = 0;
    for (int i = 1; i < f.size(); i++) if (f[i] > f[bi]) bi = i;
    sec = 0;
    for (int i = 0; i < f.size(); i++) if (i != bi && f[i] > sec) sec = f[i];
    c = bi; mx = f[bi]; mg = f[bi] - sec;
  endfunction

  initial forever begin
    @(posedge clk);
    e_vld = 0;
    if (rst) begin
      q.delete();
      e_cls = 0; e_max = 0; e_mar = 0; e_conf = 0;
    end else if (bus.clear) begin
      q.delete();
    end else if (bus.score_in_valid) begin
      q.push_back(int'(bus.score_in));
      if (q.size() == NC) begin
        eval(q, e_cls, e_max, e_mar);
        e_conf = (e_mar >= CM);
        e_vld  = 1;
        q.delete();
      end
    end
    e_busy = (q.size() > 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus.result_valid) pulses.push_back(cyc);
    chk("result_valid", int'(bus.result_valid), int'(e_vld));
    chk("busy",         int'(bus.busy),         int'(e_busy));
    chk("class_out",    int'(bus.class_out),    e_cls);
    chk("max_score",    int'(bus.max_score),    e_max);
    chk("margin",       int'(bus.margin),       e_mar);
    chk("confident",    int'(bus.confident),    int'(e_conf));
  end

  // ---------------- directed stimulus ----------------
  int f1[NC] = '{10, 200, 50, 199, 0, 3, 7, 9, 1, 2};
  int f2[NC] = '{128, 128, 128, 128, 128, 128, 128, 128, 128, 128};
  int f3[NC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 256};
  int fb[NC] = '{5, 6, 7, 8, 9, 100, 20, 30, 40, 50};
  int f4[NC] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};

  task automatic beat(input int s);
    bus.score_in       = s[SW-1:0];
    bus.score_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.score_in_valid = 1'b0;
  endtask

  task automatic frame(input int f[NC], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      beat(f[i]);
    end
  endtask

  task automatic expect_res(input string tag, input int c, input int mx, input int mg, input int cf);
    int k;
    k = 0;
    while (!bus.result_valid && k < 50) begin @(negedge clk); k++; end
    chk({tag, " pulse"}, int'(bus.result_valid), 1);
    chk({tag, " class_out"}, int'(bus.class_out), c);
    chk({tag, " max_score"}, int'(bus.max_score), mx);
    chk({tag, " margin"},    int'(bus.margin),    mg);
    chk({tag, " confident"}, int'(bus.confident), cf);
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, " class_out"},    int'(bus.class_out),    0);
    chk({tag, " max_score"},    int'(bus.max_score),    0);
    chk({tag, " margin"},       int'(bus.margin),       0);
    chk({tag, " confident"},    int'(bus.confident),    0);
    chk({tag, " result_valid"}, int'(bus.result_valid), 0);
    chk({tag, " busy"},         int'(bus.busy),         0);
  endtask

  initial begin
    int np;
    bus.score_in = '0; bus.score_in_valid = 1'b0; bus.clear = 1'b0;
    repeat (2) @(posedge clk); #1;
    expect_zero("reset");
    rst = 1'b0;

    frame(f1, NC, 1'b0);
    expect_res("mixed", 1, 200, 1, 0);

    frame(f2, NC, 1'b0);
    expect_res("tie", 0, 128, 0, 0);

    frame(f3, NC, 1'b1);
    expect_res("gaps", 9, 256, 256, 1);

    // Back-to-back: frame 2 first beat sampled during frame 1 pulse cycle.
    repeat (2) begin @(posedge clk); #1; end
    np = pulses.size();
    frame(f1, NC, 1'b0);
    frame(fb, NC, 1'b0);
    expect_res("b2b", 5, 100, 50, 1);
    repeat (2) begin @(posedge clk); #1; end
    chk("b2b pulse count", pulses.size() - np, 2);
    if (pulses.size() - np == 2)
      chk("b2b pulse spacing", pulses[np+1] - pulses[np], 10);

    // clear together with the 10th score: no result, old result held.
    frame(f4, NC - 1, 1'b0);
    np = pulses.size();
    bus.clear = 1'b1; bus.score_in_valid = 1'b1; bus.score_in = 9'd3;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.score_in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("clear no pulse", pulses.size() - np, 0);
    chk("clear held class", int'(bus.class_out), 5);
    chk("clear held max",   int'(bus.max_score), 100);
    chk("clear busy",       int'(bus.busy), 0);
    frame(f4, NC, 1'b0);
    expect_res("after clear", 5, 9, 3, 0);

    // rst mid-frame.
    repeat (2) begin @(posedge clk); #1; end
    frame(f1, 5, 1'b0);
    chk("busy mid-frame", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    expect_zero("mid rst");
    rst = 1'b0;
    np = pulses.size();
    frame(f1, NC, 1'b1);
    expect_res("after rst", 1, 200, 1, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("after rst pulses", pulses.size() - np, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
